// File: rtl/spi_tx_dma.sv
// Memory-to-SPI streaming engine: fetches 32-bit words from the host bus and
// pushes them byte by byte into the SPI controller TX register, polling STATUS first.
module spi_tx_dma #(
    parameter logic [31:0] SpiBaseAddr = 32'h8000_3000,
    parameter int unsigned LenWidth    = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cfg_req_i,
    input  logic [31:0] cfg_addr_i,
    input  logic        cfg_we_i,
    input  logic [31:0] cfg_wdata_i,
    output logic        cfg_rvalid_o,
    output logic [31:0] cfg_rdata_o,
    output logic        host_req_o,
    output logic [31:0] host_addr_o,
    input  logic        host_gnt_i,
    input  logic        host_rvalid_i,
    input  logic [31:0] host_rdata_i,
    output logic        spi_req_o,
    output logic [31:0] spi_addr_o,
    output logic        spi_we_o,
    output logic [3:0]  spi_be_o,
    output logic [31:0] spi_wdata_o,
    input  logic        spi_rvalid_i,
    input  logic [31:0] spi_rdata_i,
    output logic        irq_o
);

    localparam logic [31:0] TxAddr     = SpiBaseAddr;
    localparam logic [31:0] StatusAddr = SpiBaseAddr + 32'h10;

    // state      | meaning
    // S_IDLE     | waiting for start
    // S_FETCH    | host word request held until granted
    // S_FETCH_WAIT | waiting for host read data
    // S_POLL     | issue SPI STATUS read
    // S_POLL_WAIT | wait for STATUS, retry while TX FIFO full
    // S_PUSH     | issue SPI TX byte write
    // S_PUSH_WAIT | wait for write response, advance pointer/count
    // S_DONE     | completion: set done, pulse irq
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_FETCH_WAIT, S_POLL, S_POLL_WAIT, S_PUSH, S_PUSH_WAIT, S_DONE
    } state_t;

    state_t                r_state, w_state_next;
    logic [31:0]           r_src;
    logic [LenWidth-1:0]   r_len;
    logic [31:0]           r_cur_addr;
    logic [LenWidth-1:0]   r_remaining;
    logic [31:0]           r_word;
    logic                  r_busy, r_done, r_aborted, r_abort_pending;
    logic                  r_cfg_rvalid;
    logic [31:0]           r_cfg_rdata;

    logic [3:0]  w_off;
    logic        w_cfg_wr, w_ctrl_wr, w_start, w_abort, w_abort_any;
    logic        w_load_word, w_step, w_abort_exit;
    logic [31:0] w_next_addr, w_status, w_rdata;
    logic [15:0] w_rem_field;
    logic        w_unused;

    assign w_off       = cfg_addr_i[3:0];
    assign w_cfg_wr    = cfg_req_i & cfg_we_i;
    assign w_ctrl_wr   = w_cfg_wr && (w_off == 4'h8);
    // Start only counts when idle; abort only when busy, so a combined write resolves by state.
    assign w_start     = w_ctrl_wr && cfg_wdata_i[0] && !r_busy;
    assign w_abort     = w_ctrl_wr && cfg_wdata_i[1] && r_busy;
    assign w_abort_any = r_abort_pending | w_abort;
    assign w_next_addr = r_cur_addr + 32'd1;
    assign w_rem_field = 16'(r_remaining);
    assign w_status    = {w_rem_field, 13'd0, r_aborted, r_done, r_busy};
    assign w_unused    = ^{cfg_addr_i[31:4], spi_rdata_i[31:2], spi_rdata_i[0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load_word  = 1'b0;
        w_step       = 1'b0;
        w_abort_exit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_next = (r_len == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                if (host_gnt_i) w_state_next = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                if (host_rvalid_i) begin
                    if (w_abort_any) begin
                        w_abort_exit = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_load_word  = 1'b1;
                        w_state_next = S_POLL;
                    end
                end
            end
            S_POLL: w_state_next = S_POLL_WAIT;
            S_POLL_WAIT: begin
                if (spi_rvalid_i) begin
                    if (w_abort_any) begin
                        w_abort_exit = 1'b1;
                        w_state_next = S_IDLE;
                    end else if (spi_rdata_i[1]) begin
                        w_state_next = S_POLL;
                    end else begin
                        w_state_next = S_PUSH;
                    end
                end
            end
            S_PUSH: w_state_next = S_PUSH_WAIT;
            S_PUSH_WAIT: begin
                if (spi_rvalid_i) begin
                    w_step = 1'b1;
                    if (w_abort_any) begin
                        w_abort_exit = 1'b1;
                        w_state_next = S_IDLE;
                    end else if (r_remaining == LenWidth'(1)) begin
                        w_state_next = S_DONE;
                    end else if (w_next_addr[1:0] == 2'b00) begin
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_POLL;
                    end
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_src           <= '0;
            r_len           <= '0;
            r_cur_addr      <= '0;
            r_remaining     <= '0;
            r_word          <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_aborted       <= 1'b0;
            r_abort_pending <= 1'b0;
        end else begin
            if (w_cfg_wr && !r_busy && (w_off == 4'h0)) r_src <= cfg_wdata_i;
            if (w_cfg_wr && !r_busy && (w_off == 4'h4)) r_len <= cfg_wdata_i[LenWidth-1:0];
            if (w_start) begin
                r_cur_addr      <= r_src;
                r_remaining     <= r_len;
                r_busy          <= 1'b1;
                r_done          <= 1'b0;
                r_aborted       <= 1'b0;
                r_abort_pending <= 1'b0;
            end
            if (w_abort)     r_abort_pending <= 1'b1;
            if (w_load_word) r_word <= host_rdata_i;
            if (w_step) begin
                r_cur_addr  <= w_next_addr;
                r_remaining <= r_remaining - LenWidth'(1);
            end
            if (r_state == S_DONE) begin
                r_done          <= 1'b1;
                r_busy          <= 1'b0;
                r_abort_pending <= 1'b0;
            end
            if (w_abort_exit) begin
                r_aborted       <= 1'b1;
                r_done          <= 1'b0;
                r_busy          <= 1'b0;
                r_abort_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_off)
            4'h0:    w_rdata = r_src;
            4'h4:    w_rdata = 32'(r_len);
            4'hC:    w_rdata = w_status;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cfg_rvalid <= 1'b0;
            r_cfg_rdata  <= '0;
        end else begin
            r_cfg_rvalid <= cfg_req_i;
            r_cfg_rdata  <= (cfg_req_i && !cfg_we_i) ? w_rdata : 32'd0;
        end
    end

    assign cfg_rvalid_o = r_cfg_rvalid;
    assign cfg_rdata_o  = r_cfg_rdata;

    assign host_req_o  = (r_state == S_FETCH);
    assign host_addr_o = (r_state == S_FETCH) ? {r_cur_addr[31:2], 2'b00} : 32'd0;

    assign spi_req_o   = (r_state == S_POLL) || (r_state == S_PUSH);
    assign spi_we_o    = (r_state == S_PUSH);
    assign spi_addr_o  = (r_state == S_PUSH) ? TxAddr :
                         (r_state == S_POLL) ? StatusAddr : 32'd0;
    assign spi_be_o    = (r_state == S_PUSH) ? 4'b0001 :
                         (r_state == S_POLL) ? 4'b1111 : 4'b0000;
    // Little-endian byte select from the latched word.
    assign spi_wdata_o = (r_state == S_PUSH) ?
                         {24'd0, r_word[{r_cur_addr[1:0], 3'b000} +: 8]} : 32'd0;

    assign irq_o = (r_state == S_DONE);

endmodule

// File: tb/tb_spi_tx_dma.sv
// Directed bench for spi_tx_dma: bus responders, a per-byte transaction model and
// a cycle monitor comparing every host/SPI request against the model.
module tb_spi_tx_dma;

    localparam logic [31:0] Base = 32'h8000_3000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cfg_req_i = 1'b0, cfg_we_i = 1'b0;
    logic [31:0] cfg_addr_i = '0, cfg_wdata_i = '0;
    logic        cfg_rvalid_o;
    logic [31:0] cfg_rdata_o;
    logic        host_req_o;
    logic [31:0] host_addr_o;
    logic        host_gnt_i = 1'b1, host_rvalid_i = 1'b0;
    logic [31:0] host_rdata_i = '0;
    logic        spi_req_o, spi_we_o;
    logic [31:0] spi_addr_o, spi_wdata_o;
    logic [3:0]  spi_be_o;
    logic        spi_rvalid_i = 1'b0;
    logic [31:0] spi_rdata_i = '0;
    logic        irq_o;

    spi_tx_dma dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cfg_req_i(cfg_req_i), .cfg_addr_i(cfg_addr_i), .cfg_we_i(cfg_we_i),
        .cfg_wdata_i(cfg_wdata_i), .cfg_rvalid_o(cfg_rvalid_o), .cfg_rdata_o(cfg_rdata_o),
        .host_req_o(host_req_o), .host_addr_o(host_addr_o), .host_gnt_i(host_gnt_i),
        .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i),
        .spi_req_o(spi_req_o), .spi_addr_o(spi_addr_o), .spi_we_o(spi_we_o),
        .spi_be_o(spi_be_o), .spi_wdata_o(spi_wdata_o), .spi_rvalid_i(spi_rvalid_i),
        .spi_rdata_i(spi_rdata_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } spi_t;

    spi_t        exp_spi[$];
    logic [31:0] exp_host[$];
    logic [7:0]  wr_log[$];
    logic [31:0] mem [0:63];

    int n_checks = 0, n_fail = 0;
    int irq_cnt, spi_cnt, poll_cnt, host_cnt;
    int full_at, full_left, writes_seen;
    logic spi_pend = 1'b0, spi_pend_we = 1'b0, host_pend = 1'b0, prev_spi = 1'b0;
    logic [31:0] host_pend_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Memory and SPI controller: answer one cycle after each accepted request.
    initial forever begin
        @(negedge clk_i);
        spi_rvalid_i = spi_pend;
        spi_rdata_i  = 32'd0;
        if (spi_pend && !spi_pend_we && full_left > 0 && writes_seen == full_at) begin
            spi_rdata_i = 32'h2;
            full_left--;
        end
        host_rvalid_i = host_pend;
        host_rdata_i  = host_pend ? mem[host_pend_addr[7:2]] : 32'd0;
        #4;
        spi_pend       = spi_req_o;
        spi_pend_we    = spi_we_o;
        if (spi_req_o && spi_we_o) writes_seen++;
        host_pend      = host_req_o && host_gnt_i;
        host_pend_addr = host_addr_o;
    end

    // Compare every bus request the DUT makes against the model queues.
    initial forever begin
        @(negedge clk_i);
        #4;
        if (!rst_ni) begin
            prev_spi = 1'b0;
        end else begin
            if (spi_req_o) begin
                spi_t e;
                spi_cnt++;
                if (!spi_we_o) poll_cnt++;
                if (prev_spi) fail_now("spi_req_while_outstanding");
                if (exp_spi.size() == 0) begin
                    fail_now("spi_unexpected_request");
                end else begin
                    e = exp_spi.pop_front();
                    check("spi_we", {31'd0, spi_we_o}, {31'd0, e.we});
                    check("spi_addr", spi_addr_o, e.addr);
                    check("spi_be", {28'd0, spi_be_o}, {28'd0, e.be});
                    if (e.we) check("spi_wdata", spi_wdata_o, e.wdata);
                end
                if (spi_we_o) wr_log.push_back(spi_wdata_o[7:0]);
            end
            prev_spi = spi_req_o;
            if (host_req_o && host_gnt_i) begin
                host_cnt++;
                if (exp_host.size() == 0) fail_now("host_unexpected_request");
                else check("host_addr", host_addr_o, exp_host.pop_front());
            end
            if (irq_o) irq_cnt++;
        end
    end

    // Transfer model: one host read per touched word, polls then one write per byte.
    task automatic model_xfer(input logic [31:0] src, input int len, input int full_idx,
                              input int full_n);
        logic [31:0] a;
        logic [31:0] w;
        spi_t e;
        for (int i = 0; i < len; i++) begin
            a = src + i;
            if (i == 0 || a[1:0] == 2'b00) exp_host.push_back({a[31:2], 2'b00});
            for (int r = 0; r <= ((i == full_idx) ? full_n : 0); r++) begin
                e = '{1'b0, Base + 32'h10, 4'hF, 32'h0};
                exp_spi.push_back(e);
            end
            w = mem[a[7:2]];
            e = '{1'b1, Base, 4'h1, {24'h0, 8'(w >> (8 * a[1:0]))}};
            exp_spi.push_back(e);
        end
    endtask

    task automatic clear_counts();
        irq_cnt = 0; spi_cnt = 0; poll_cnt = 0; host_cnt = 0;
        writes_seen = 0; full_left = 0; full_at = -1;
        wr_log.delete();
    endtask

    task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk_i);
        cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = addr; cfg_wdata_i = data;
        @(negedge clk_i);
        cfg_req_i = 1'b0; cfg_we_i = 1'b0;
        check("cfg_write_rvalid", {31'd0, cfg_rvalid_o}, 32'd1);
    endtask

    task automatic cfg_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk_i);
        cfg_req_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = addr;
        @(negedge clk_i);
        cfg_req_i = 1'b0;
        check("cfg_read_rvalid", {31'd0, cfg_rvalid_o}, 32'd1);
        data = cfg_rdata_o;
    endtask

    task automatic wait_idle(output logic [31:0] status);
        status = 32'hFFFF_FFFF;
        for (int k = 0; k < 400; k++) begin
            cfg_read(32'hC, status);
            if (!status[0]) break;
        end
        if (status[0]) fail_now("wait_idle_timeout");
    endtask

    task automatic run_xfer(input logic [31:0] src, input int len, input int fidx, input int fn);
        logic [31:0] st;
        clear_counts();
        full_at = fidx; full_left = fn;
        model_xfer(src, len, fidx, fn);
        cfg_write(32'h0, src);
        cfg_write(32'h4, len);
        cfg_write(32'h8, 32'h1);
        wait_idle(st);
        check("xfer_status", st, 32'h0000_0002);
        check("xfer_irq_count", irq_cnt, 1);
        check("xfer_spi_left", exp_spi.size(), 0);
        check("xfer_host_left", exp_host.size(), 0);
    endtask

    task automatic check_bytes_3344556677();
        logic [7:0] eb [5];
        eb = '{8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        check("byte_count", wr_log.size(), 5);
        for (int i = 0; i < 5 && i < wr_log.size(); i++) check("byte_value", wr_log[i], eb[i]);
    endtask

    initial begin
        logic [31:0] rd;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0101_0101 * i;
        mem[0] = 32'h4433_2211;
        mem[1] = 32'h8877_6655;
        clear_counts();

        // Reset values
        repeat (2) @(negedge clk_i);
        check("rst_host_req", {31'd0, host_req_o}, 32'd0);
        check("rst_spi_req", {31'd0, spi_req_o}, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        check("rst_cfg_rvalid", {31'd0, cfg_rvalid_o}, 32'd0);
        rst_ni = 1'b1;
        cfg_read(32'hC, rd); check("rst_status", rd, 32'd0);
        cfg_read(32'h0, rd); check("rst_src", rd, 32'd0);
        cfg_read(32'h4, rd); check("rst_len", rd, 32'd0);

        // Config regression
        cfg_write(32'h0, 32'hDEAD_BEEF);
        cfg_write(32'h4, 32'hFFFF_1234);
        cfg_read(32'h0, rd); check("cfg_src_rb", rd, 32'hDEAD_BEEF);
        cfg_read(32'h4, rd); check("cfg_len_rb", rd, 32'h0000_1234);
        cfg_read(32'h8, rd); check("cfg_ctrl_rb", rd, 32'd0);
        cfg_read(32'h1, rd); check("cfg_unmapped_rb", rd, 32'd0);

        // Basic transfer, FIFO never full
        run_xfer(32'h102, 5, -1, 0);
        check_bytes_3344556677();
        check("t1_host_reads", host_cnt, 2);
        check("t1_spi_txns", spi_cnt, 10);
        check("t1_polls", poll_cnt, 5);

        // FIFO full for three polls before the 2nd byte
        run_xfer(32'h102, 5, 1, 3);
        check_bytes_3344556677();
        check("t2_spi_txns", spi_cnt, 13);
        check("t2_polls", poll_cnt, 8);

        // Zero-length transfer
        clear_counts();
        cfg_write(32'h4, 32'h0);
        cfg_write(32'h8, 32'h1);
        @(negedge clk_i);
        check("len0_irq_within_2", irq_cnt, 1);
        wait_idle(rd);
        check("len0_status", rd, 32'h0000_0002);
        check("len0_irq_total", irq_cnt, 1);
        check("len0_spi_txns", spi_cnt, 0);
        check("len0_host_reads", host_cnt, 0);

        // Abort while the word fetch is stalled, SRC write ignored while busy
        clear_counts();
        host_gnt_i = 1'b0;
        cfg_write(32'h0, 32'h200);
        cfg_write(32'h4, 32'd8);
        exp_host.push_back(32'h200);
        cfg_write(32'h8, 32'h1);
        repeat (2) @(negedge clk_i);
        check("abort_fetch_req", {31'd0, host_req_o}, 32'd1);
        check("abort_fetch_addr", host_addr_o, 32'h200);
        cfg_write(32'h0, 32'h1111_1111);
        cfg_read(32'h0, rd); check("src_locked_busy", rd, 32'h200);
        cfg_write(32'h8, 32'h3);
        repeat (3) @(negedge clk_i);
        check("abort_req_held", {31'd0, host_req_o}, 32'd1);
        host_gnt_i = 1'b1;
        wait_idle(rd);
        check("abort_status", rd, 32'h0008_0004);
        check("abort_irq", irq_cnt, 0);
        check("abort_spi_txns", spi_cnt, 0);
        check("abort_host_reads", host_cnt, 1);
        repeat (4) @(negedge clk_i);
        check("abort_quiet_spi", spi_cnt, 0);

        // Reset in the middle of a byte push
        clear_counts();
        model_xfer(32'h102, 5, -1, 0);
        cfg_write(32'h0, 32'h102);
        cfg_write(32'h4, 32'd5);
        cfg_write(32'h8, 32'h1);
        begin
            int k;
            for (k = 0; k < 200; k++) begin
                @(negedge clk_i);
                if (spi_req_o && spi_we_o) break;
            end
            if (k == 200) fail_now("push_wait_timeout");
        end
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_host_req", {31'd0, host_req_o}, 32'd0);
        check("mid_rst_host_addr", host_addr_o, 32'd0);
        check("mid_rst_spi_req", {31'd0, spi_req_o}, 32'd0);
        check("mid_rst_spi_we", {31'd0, spi_we_o}, 32'd0);
        check("mid_rst_spi_addr", spi_addr_o, 32'd0);
        check("mid_rst_spi_be", {28'd0, spi_be_o}, 32'd0);
        check("mid_rst_spi_wdata", spi_wdata_o, 32'd0);
        check("mid_rst_irq", {31'd0, irq_o}, 32'd0);
        check("mid_rst_cfg_rdata", cfg_rdata_o, 32'd0);
        repeat (2) @(negedge clk_i);
        exp_spi.delete();
        exp_host.delete();
        rst_ni = 1'b1;
        cfg_read(32'hC, rd); check("post_rst_status", rd, 32'd0);
        run_xfer(32'h102, 5, -1, 0);
        check_bytes_3344556677();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
